// File: rtl/cci_mpf_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
// cci_mpf_wr_arb_pkg
//   Shared types for the packet-granular c1 Tx write arbiter.
//   Revision: 1.0
// ============================================================================
package cci_mpf_wr_arb_pkg;

  localparam int MAX_BEATS = 4;
  localparam int N_REQ_MAX = 8;
  localparam int IDX_BITS  = 3;

  typedef logic [1:0]          t_cci_clLen;
  typedef logic [IDX_BITS-1:0] t_wr_arb_idx;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } t_wr_arb_state;

  // Round-robin successor of idx among n_req sources.
  function automatic t_wr_arb_idx wr_arb_next_idx(input t_wr_arb_idx idx, input int n_req);
    return (int'(idx) == n_req - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cci_mpf_prim_wr_packet_arb_if.sv
`default_nettype none
// ============================================================================
// cci_mpf_prim_wr_packet_arb_if
//   Per-source c1 Tx write inputs and the merged write output bus.
//   Revision: 1.0
// ============================================================================
interface cci_mpf_prim_wr_packet_arb_if
  import cci_mpf_wr_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int N_HDR_BITS  = 80,
  parameter int N_DATA_BITS = 512
);
  localparam int SRC_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_sop;
  logic [N_REQ*2-1:0]           req_cl_len;
  logic [N_REQ*N_HDR_BITS-1:0]  req_hdr;
  logic [N_REQ*N_DATA_BITS-1:0] req_data;
  logic [N_REQ-1:0]             req_almFull;
  logic                         out_almFull;
  logic                         out_valid;
  logic                         out_sop;
  t_cci_clLen                   out_cl_len;
  logic [N_HDR_BITS-1:0]        out_hdr;
  logic [N_DATA_BITS-1:0]       out_data;
  logic [SRC_BITS-1:0]          out_src;

  modport master (
    output req_valid, req_sop, req_cl_len, req_hdr, req_data, out_almFull,
    input  req_almFull, out_valid, out_sop, out_cl_len, out_hdr, out_data, out_src
  );

  modport slave (
    input  req_valid, req_sop, req_cl_len, req_hdr, req_data, out_almFull,
    output req_almFull, out_valid, out_sop, out_cl_len, out_hdr, out_data, out_src
  );
endinterface
`default_nettype wire

// File: rtl/cci_mpf_prim_fifo_lutram.sv
`default_nettype none
// ============================================================================
// cci_mpf_prim_fifo_lutram
//   Small show-ahead FIFO with almost-full flag, distributed-RAM style.
//   Revision: 1.0
// ============================================================================
module cci_mpf_prim_fifo_lutram #(
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES   = 12,
  parameter int THRESHOLD   = 8
) (
  input  wire logic                   clk,
  input  wire logic                   reset_n,
  input  wire logic [N_DATA_BITS-1:0] enq_data,
  input  wire logic                   enq_en,
  output logic                        notEmpty,
  output logic                        almostFull,
  output logic [N_DATA_BITS-1:0]      first,
  input  wire logic                   deq_en
);
  localparam int c_ptr_w = $clog2(N_ENTRIES);
  localparam int c_cnt_w = $clog2(N_ENTRIES + 1);
  localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(N_ENTRIES - 1);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(N_ENTRIES);
  localparam logic [c_cnt_w-1:0] c_af   = c_cnt_w'(N_ENTRIES - THRESHOLD);

  logic [N_DATA_BITS-1:0] r_mem [N_ENTRIES];
  logic [c_ptr_w-1:0]     r_wr_ptr;
  logic [c_ptr_w-1:0]     r_rd_ptr;
  logic [c_cnt_w-1:0]     r_count;
  logic                   w_enq;
  logic                   w_deq;

  assign w_enq      = enq_en && (r_count != c_full);
  assign w_deq      = deq_en && (r_count != '0);
  assign notEmpty   = (r_count != '0);
  assign almostFull = (r_count >= c_af);
  assign first      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wr_ptr] <= enq_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/cci_mpf_prim_wr_arb_rr.sv
`default_nettype none
// ============================================================================
// cci_mpf_prim_wr_arb_rr
//   Combinational round-robin picker: first eligible index at or after rr_ptr.
//   Revision: 1.0
// ============================================================================
module cci_mpf_prim_wr_arb_rr
  import cci_mpf_wr_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  wire logic [N_REQ-1:0] eligible,
  input  wire t_wr_arb_idx      rr_ptr,
  output t_wr_arb_idx           grant_idx,
  output logic                  grant_valid
);
  logic [N_REQ_MAX-1:0] w_elig;
  t_wr_arb_idx          w_cand;

  always_comb begin
    w_elig              = '0;
    w_elig[N_REQ-1:0]   = eligible;
    grant_idx           = rr_ptr;
    grant_valid         = 1'b0;
    w_cand              = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_valid && w_elig[w_cand]) begin
        grant_idx   = w_cand;
        grant_valid = 1'b1;
      end
      w_cand = wr_arb_next_idx(w_cand, N_REQ);
    end
  end
endmodule
`default_nettype wire

// File: rtl/cci_mpf_prim_wr_packet_arb.sv
`default_nettype none
// ============================================================================
// cci_mpf_prim_wr_packet_arb
//   Round-robin merge of N_REQ c1 Tx write sources; multi-beat packets never interleave.
//   Revision: 1.0
// ============================================================================
module cci_mpf_prim_wr_packet_arb
  import cci_mpf_wr_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int N_HDR_BITS  = 80,
  parameter int N_DATA_BITS = 512,
  parameter int THRESHOLD   = 8
) (
  input wire logic clk,
  input wire logic reset_n,
  cci_mpf_prim_wr_packet_arb_if.slave bus
);
  localparam int c_src_bits  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_beat_bits = 1 + 2 + N_HDR_BITS + N_DATA_BITS;

  logic [c_beat_bits-1:0] w_head [N_REQ];
  logic [N_REQ-1:0]       w_not_empty;
  logic [N_REQ-1:0]       w_fifo_af;
  logic [N_REQ-1:0]       w_deq;

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_src
      logic       r_alm_full;
      t_cci_clLen r_in_rem;
      t_cci_clLen w_in_rem_nxt;
      logic       w_in_sop;
      t_cci_clLen w_in_len;

      assign w_in_sop = bus.req_sop[i];
      assign w_in_len = bus.req_cl_len[2*i +: 2];

      // Beats still owed by this source for its current packet on the input side.
      always_comb begin
        w_in_rem_nxt = r_in_rem;
        if (bus.req_valid[i]) begin
          if (w_in_sop)                w_in_rem_nxt = w_in_len;
          else if (r_in_rem != 2'd0)   w_in_rem_nxt = r_in_rem - 2'd1;
        end
      end

      // Almost-full may fall mid-packet but is never raised until the packet is complete.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_in_rem   <= 2'd0;
          r_alm_full <= 1'b1;
        end else begin
          r_in_rem   <= w_in_rem_nxt;
          r_alm_full <= (w_in_rem_nxt != 2'd0) ? (r_alm_full & w_fifo_af[i]) : w_fifo_af[i];
        end
      end

      assign bus.req_almFull[i] = r_alm_full;

      cci_mpf_prim_fifo_lutram #(
        .N_DATA_BITS (c_beat_bits),
        .N_ENTRIES   (THRESHOLD + 4),
        .THRESHOLD   (THRESHOLD)
      ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .enq_data   ({w_in_sop, w_in_len,
                      bus.req_hdr[i*N_HDR_BITS +: N_HDR_BITS],
                      bus.req_data[i*N_DATA_BITS +: N_DATA_BITS]}),
        .enq_en     (bus.req_valid[i]),
        .notEmpty   (w_not_empty[i]),
        .almostFull (w_fifo_af[i]),
        .first      (w_head[i]),
        .deq_en     (w_deq[i])
      );
    end
  endgenerate

  t_wr_arb_state          r_state;
  t_wr_arb_idx            r_rr_ptr;
  t_wr_arb_idx            r_grant;
  t_cci_clLen             r_beats_rem;
  logic                   r_out_valid;
  logic                   r_out_sop;
  t_cci_clLen             r_out_cl_len;
  logic [N_HDR_BITS-1:0]  r_out_hdr;
  logic [N_DATA_BITS-1:0] r_out_data;
  logic [c_src_bits-1:0]  r_out_src;

  t_wr_arb_idx            w_pick_idx;
  logic                   w_pick_valid;
  t_wr_arb_idx            w_sel;
  logic                   w_sel_valid;
  logic [c_beat_bits-1:0] w_sel_beat;
  logic                   w_sel_sop;
  t_cci_clLen             w_sel_cl_len;
  logic                   w_fire;

  cci_mpf_prim_wr_arb_rr #(.N_REQ(N_REQ)) u_rr (
    .eligible    (w_not_empty),
    .rr_ptr      (r_rr_ptr),
    .grant_idx   (w_pick_idx),
    .grant_valid (w_pick_valid)
  );

  always_comb begin
    w_sel       = (r_state == PKT) ? r_grant : w_pick_idx;
    w_sel_valid = 1'b0;
    w_sel_beat  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (int'(w_sel) == j) begin
        w_sel_valid = w_not_empty[j];
        w_sel_beat  = w_head[j];
      end
    end
    if (r_state == IDLE) w_sel_valid = w_sel_valid && w_pick_valid;
    w_fire = !bus.out_almFull && w_sel_valid;
    w_deq  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      w_deq[j] = w_fire && (int'(w_sel) == j);
    end
  end

  assign w_sel_sop    = w_sel_beat[c_beat_bits-1];
  assign w_sel_cl_len = w_sel_beat[c_beat_bits-2 -: 2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_beats_rem <= 2'd0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_fire;
      if (w_fire) begin
        r_out_sop    <= w_sel_sop;
        r_out_cl_len <= w_sel_cl_len;
        r_out_hdr    <= w_sel_beat[N_DATA_BITS +: N_HDR_BITS];
        r_out_data   <= w_sel_beat[N_DATA_BITS-1:0];
        r_out_src    <= w_sel[c_src_bits-1:0];
      end
`ifndef SYNTHESIS
      if (w_fire && r_state == IDLE && !w_sel_sop)
        $fatal(1, "wr_packet_arb: packet from source %0d does not start with SOP", w_sel);
      if (w_fire && r_state == IDLE && w_sel_sop && w_sel_cl_len == 2'd2)
        $fatal(1, "wr_packet_arb: illegal cl_len 2 from source %0d", w_sel);
      if (w_fire && r_state == PKT && w_sel_sop)
        $fatal(1, "wr_packet_arb: SOP inside packet from source %0d", w_sel);
`endif
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            // Malformed (non-SOP) heads are passed through as single beats.
            if (!w_sel_sop || w_sel_cl_len == 2'd0) begin
              r_rr_ptr <= wr_arb_next_idx(w_sel, N_REQ);
            end else begin
              r_state     <= PKT;
              r_grant     <= w_sel;
              r_beats_rem <= w_sel_cl_len;
            end
          end
        end
        PKT: begin
          if (w_fire) begin
            if (w_sel_sop || r_beats_rem == 2'd1) begin
              r_state     <= IDLE;
              r_rr_ptr    <= wr_arb_next_idx(r_grant, N_REQ);
              r_beats_rem <= 2'd0;
            end else begin
              r_beats_rem <= r_beats_rem - 2'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_sop    = r_out_sop;
  assign bus.out_cl_len = r_out_cl_len;
  assign bus.out_hdr    = r_out_hdr;
  assign bus.out_data   = r_out_data;
  assign bus.out_src    = r_out_src;
endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_prim_wr_packet_arb.sv
`default_nettype none
// ============================================================================
// tb_cci_mpf_prim_wr_packet_arb
//   Directed self-checking bench for the packet write arbiter.
//   Revision: 1.0
// ============================================================================
module tb_cci_mpf_prim_wr_packet_arb;
  localparam int N_REQ       = 4;
  localparam int N_HDR_BITS  = 80;
  localparam int N_DATA_BITS = 512;
  localparam int THRESHOLD   = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  cci_mpf_prim_wr_packet_arb_if #(
    .N_REQ(N_REQ), .N_HDR_BITS(N_HDR_BITS), .N_DATA_BITS(N_DATA_BITS)
  ) bus ();

  cci_mpf_prim_wr_packet_arb #(
    .N_REQ(N_REQ), .N_HDR_BITS(N_HDR_BITS), .N_DATA_BITS(N_DATA_BITS), .THRESHOLD(THRESHOLD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid  = '0;
    bus.req_sop    = '0;
    bus.req_cl_len = '0;
    bus.req_hdr    = '0;
    bus.req_data   = '0;
  endtask

  task automatic drive(input int src, input logic sop, input logic [1:0] len, input logic [15:0] id);
    bus.req_valid[src]                              = 1'b1;
    bus.req_sop[src]                                = sop;
    bus.req_cl_len[2*src +: 2]                      = len;
    bus.req_hdr[src*N_HDR_BITS +: N_HDR_BITS]       = N_HDR_BITS'(id);
    bus.req_data[src*N_DATA_BITS +: N_DATA_BITS]    = {32{id}};
  endtask

  task automatic expect_beat(input string tag, input int src, input logic sop,
                             input logic [1:0] len, input logic [15:0] id);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, ".src"},   64'(bus.out_src), 64'(src));
    check({tag, ".sop"},   64'(bus.out_sop), 64'(sop));
    check({tag, ".len"},   64'(bus.out_cl_len), 64'(len));
    check({tag, ".hdr"},   bus.out_hdr[63:0], 64'(id));
    check({tag, ".data"},  bus.out_data[N_DATA_BITS-1 -: 64], {4{id}});
  endtask

  task automatic expect_idle(input string tag);
    check(tag, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    clear_inputs();
    bus.out_almFull = 1'b0;

    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    check("rst.valid",   64'(bus.out_valid), 64'd0);
    check("rst.almfull", 64'(bus.req_almFull), 64'hF);
    reset_n = 1'b1;
    tick();
    check("rst.almfull_rel", 64'(bus.req_almFull), 64'h0);
    expect_idle("rst.idle");

    // Single-beat round robin, all four sources in one cycle
    for (int s = 0; s < N_REQ; s++) drive(s, 1'b1, 2'd0, 16'(16'h1000 + s));
    tick();
    clear_inputs();
    expect_idle("t1.early");
    for (int s = 0; s < N_REQ; s++) begin
      tick();
      expect_beat($sformatf("t1.b%0d", s), s, 1'b1, 2'd0, 16'(16'h1000 + s));
    end
    tick();
    expect_idle("t1.end");

    // 4-beat packet from src1 against continuous single beats from src0
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      drive(0, 1'b1, 2'd0, 16'(16'h2000 + c));
      if (c < 4) drive(1, (c == 0), 2'd3, 16'(16'h2100 + c));
      tick();
      if (c == 0)      expect_idle("t2.c0");
      else if (c == 1) expect_beat("t2.a0", 0, 1'b1, 2'd0, 16'h2000);
      else             expect_beat($sformatf("t2.p%0d", c - 2), 1, (c == 2), 2'd3, 16'(16'h2100 + c - 2));
    end
    clear_inputs();
    for (int k = 1; k < 6; k++) begin
      tick();
      expect_beat($sformatf("t2.a%0d", k), 0, 1'b1, 2'd0, 16'(16'h2000 + k));
    end
    tick();
    expect_idle("t2.end");

    // Backpressure in the middle of a 2-beat packet, competing src3 waits
    clear_inputs();
    drive(2, 1'b1, 2'd1, 16'h3000);
    drive(3, 1'b1, 2'd0, 16'h3100);
    tick();
    expect_idle("t3.c0");
    clear_inputs();
    drive(2, 1'b0, 2'd1, 16'h3001);
    tick();
    expect_beat("t3.b0", 2, 1'b1, 2'd1, 16'h3000);
    clear_inputs();
    bus.out_almFull = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      expect_idle($sformatf("t3.stall%0d", k));
    end
    bus.out_almFull = 1'b0;
    tick();
    expect_beat("t3.b1", 2, 1'b0, 2'd1, 16'h3001);
    tick();
    expect_beat("t3.c", 3, 1'b1, 2'd0, 16'h3100);
    tick();
    expect_idle("t3.end");

    // Fill src2 with the output blocked, then drain
    bus.out_almFull = 1'b1;
    for (int k = 0; k < THRESHOLD + 4; k++) begin
      clear_inputs();
      drive(2, 1'b1, 2'd0, 16'(16'h4000 + k));
      tick();
      check($sformatf("t4.almfull%0d", k), 64'(bus.req_almFull[2]), 64'(k >= 4));
      expect_idle($sformatf("t4.blocked%0d", k));
    end
    clear_inputs();
    bus.out_almFull = 1'b0;
    for (int k = 0; k < THRESHOLD + 4; k++) begin
      tick();
      expect_beat($sformatf("t4.d%0d", k), 2, 1'b1, 2'd0, 16'(16'h4000 + k));
    end
    tick();
    expect_idle("t4.end");
    check("t4.almfull_drained", 64'(bus.req_almFull), 64'h0);

    // Reset after the second beat of a 4-beat packet
    clear_inputs();
    drive(0, 1'b1, 2'd3, 16'h5000);
    tick();
    expect_idle("t5.c0");
    clear_inputs();
    drive(0, 1'b0, 2'd3, 16'h5001);
    tick();
    expect_beat("t5.e0", 0, 1'b1, 2'd3, 16'h5000);
    clear_inputs();
    drive(0, 1'b0, 2'd3, 16'h5002);
    tick();
    expect_beat("t5.e1", 0, 1'b0, 2'd3, 16'h5001);
    clear_inputs();
    drive(0, 1'b0, 2'd3, 16'h5003);
    reset_n = 1'b0;
    tick();
    check("t5.rst.valid",   64'(bus.out_valid), 64'd0);
    check("t5.rst.almfull", 64'(bus.req_almFull), 64'hF);
    reset_n = 1'b1;
    clear_inputs();
    tick();
    expect_idle("t5.post0");
    check("t5.almfull_rel", 64'(bus.req_almFull), 64'h0);
    tick();
    expect_idle("t5.post1");
    drive(1, 1'b1, 2'd1, 16'h5100);
    tick();
    expect_idle("t5.f_c0");
    clear_inputs();
    drive(1, 1'b0, 2'd1, 16'h5101);
    tick();
    expect_beat("t5.f0", 1, 1'b1, 2'd1, 16'h5100);
    clear_inputs();
    tick();
    expect_beat("t5.f1", 1, 1'b0, 2'd1, 16'h5101);
    tick();
    expect_idle("t5.end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
